dma_pack_fifo: RTL and testbench

DMA_PACK_FIFO -- requirements
Module: dma_pack_fifo

---
 rtl/dma_fifo_pkg.sv | 26 ++
 rtl/dma_fifo_mem.sv | 32 +++
 rtl/dma_pack_fifo.sv | 118 +++++++++++
 tb/tb_dma_pack_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_fifo_pkg.sv
// Shared constants and the unit-select helper for the DMA pack FIFO.
package dma_fifo_pkg;

  localparam int unsigned DEF_WORD_W = 32;
  localparam int unsigned DEF_BYTE_W = 8;
  localparam int unsigned DEF_DEPTH  = 4;

  // Widest word/unit the helper can handle; callers cast down to their own width.
  localparam int unsigned MAX_WORD_W = 1024;
  localparam int unsigned MAX_BYTE_W = 512;

  // Return unit 'lane' of 'word'; lane 0 is the least significant unit when
  // lsb_first is set, otherwise the most significant one.
  function automatic logic [MAX_BYTE_W-1:0] unit_sel(
    input logic [MAX_WORD_W-1:0] word,
    input int unsigned           lane,
    input int unsigned           ratio,
    input int unsigned           byte_w,
    input logic                  lsb_first
  );
    int unsigned idx;
    idx = lsb_first ? lane : (ratio - 1 - lane);
    return MAX_BYTE_W'(word >> (idx * byte_w));
  endfunction

endpackage

// File: rtl/dma_fifo_mem.sv
// Word storage for the DMA pack FIFO: DEPTH x WORD_W registers, one write
// port, one asynchronous read port, contents not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module dma_fifo_mem #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WORD_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dma_pack_fifo.sv
// Word-in / unit-out FIFO: accepts WORD_W words and returns them as
// WORD_W/BYTE_W units of BYTE_W bits, first-word fall-through.
//   clk, rst_n          : clock, async active-low reset
//   flush               : synchronous clear of all contents
//   wr_valid/wr_ready   : word push handshake, wr_data is the word
//   rd_valid/rd_ready   : unit consume handshake, rd_data is the unit
//   rd_last             : current unit is the last of the head word
//   full, empty, level  : occupancy in words (partially read head counts)
module dma_pack_fifo
  import dma_fifo_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned BYTE_W    = DEF_BYTE_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [WORD_W-1:0]      wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [BYTE_W-1:0]      rd_data,
  output logic                   rd_last,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned R  = WORD_W / BYTE_W;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(R);

  logic [AW-1:0]     wr_ptr, wr_ptr_d;
  logic [AW-1:0]     rd_ptr, rd_ptr_d;
  logic [LW-1:0]     lane, lane_d;
  logic [AW:0]       level_q, level_d;
  logic [WORD_W-1:0] head_word;
  logic              push, consume, pop, at_last;

  // Occupancy flags and handshakes, all derived from the registered level.
  assign empty    = (level_q == '0);
  assign full     = (level_q == (AW+1)'(DEPTH));
  assign level    = level_q;
  assign wr_ready = !full;
  assign rd_valid = !empty;

  assign at_last  = (lane == LW'(R - 1));
  assign push     = wr_valid && wr_ready;
  assign consume  = rd_valid && rd_ready;
  assign pop      = consume && at_last;

  // Fall-through read path from the head entry and current lane.
  assign rd_last  = rd_valid && at_last;
  assign rd_data  = empty ? '0
                  : BYTE_W'(unit_sel(MAX_WORD_W'(head_word), 32'(lane), R, BYTE_W, LSB_FIRST));

  // Next-state for pointers, lane and level; flush wins over any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    lane_d   = lane;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      lane_d   = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr + AW'(1);
      end
      if (consume) begin
        if (at_last) begin
          lane_d   = '0;
          rd_ptr_d = rd_ptr + AW'(1);
        end else begin
          lane_d = lane + LW'(1);
        end
      end
      case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lane    <= '0;
      level_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr_d;
      rd_ptr  <= rd_ptr_d;
      lane    <= lane_d;
      level_q <= level_d;
    end
  end

  dma_fifo_mem #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head_word)
  );

endmodule

// File: tb/tb_dma_pack_fifo.sv
// Bench for dma_pack_fifo: two instances (LSB-first and MSB-first) share the
// same stimulus and are checked every cycle against a queue-based model.
module tb_dma_pack_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned R     = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, wr_valid, rd_ready;
  logic [31:0] wr_data;
  logic        wr_ready, rd_valid, rd_last, full, empty;
  logic [7:0]  rd_data;
  logic [2:0]  level;
  logic        m_wr_ready, m_rd_valid, m_rd_last, m_full, m_empty;
  logic [7:0]  m_rd_data;
  logic [2:0]  m_level;

  int checks   = 0;
  int failures = 0;

  // Reference model: stored words and read lane of the head word.
  logic [31:0] q[$];
  int          lane;

  always #5 clk = ~clk;

  dma_pack_fifo #(.WORD_W(32), .BYTE_W(8), .DEPTH(DEPTH), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .full(full), .empty(empty), .level(level));

  dma_pack_fifo #(.WORD_W(32), .BYTE_W(8), .DEPTH(DEPTH), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_valid(wr_valid), .wr_ready(m_wr_ready),
    .wr_data(wr_data), .rd_valid(m_rd_valid), .rd_ready(rd_ready), .rd_data(m_rd_data),
    .rd_last(m_rd_last), .full(m_full), .empty(m_empty), .level(m_level));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_unit(input bit lsb);
    logic [31:0] w;
    int          idx;
    if (q.size() == 0) return 8'h00;
    w   = q[0];
    idx = lsb ? lane : (R - 1 - lane);
    return w[idx*8 +: 8];
  endfunction

  // Compare both instances against the model.
  task automatic compare();
    int n;
    n = q.size();
    chk("empty",      32'(empty),      32'(n == 0));
    chk("full",       32'(full),       32'(n == DEPTH));
    chk("level",      32'(level),      32'(n));
    chk("wr_ready",   32'(wr_ready),   32'(n != DEPTH));
    chk("rd_valid",   32'(rd_valid),   32'(n != 0));
    chk("rd_last",    32'(rd_last),    32'(n != 0 && lane == R - 1));
    chk("rd_data",    32'(rd_data),    32'(exp_unit(1'b1)));
    chk("m_rd_data",  32'(m_rd_data),  32'(exp_unit(1'b0)));
    chk("m_rd_last",  32'(m_rd_last),  32'(n != 0 && lane == R - 1));
    chk("m_level",    32'(m_level),    32'(n));
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input bit wv, input logic [31:0] wd, input bit rr, input bit fl,
                      output bit accepted);
    bit push, cons;
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
    push = wv && (q.size() < DEPTH);
    cons = rr && (q.size() > 0);
    accepted = push && !fl;
    if (fl) begin
      q.delete();
      lane = 0;
    end else begin
      if (cons) begin
        if (lane == R - 1) begin
          void'(q.pop_front());
          lane = 0;
        end else begin
          lane++;
        end
      end
      if (push) q.push_back(wd);
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_empty"},    32'(empty),    32'd1);
    chk({tag, "_full"},     32'(full),     32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_last"},  32'(rd_last),  32'd0);
    chk({tag, "_rd_data"},  32'(rd_data),  32'd0);
    chk({tag, "_level"},    32'(level),    32'd0);
  endtask

  initial begin
    bit          acc;
    int          cnt;
    logic [31:0] w;

    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    lane = 0;
    #3;
    reset_literals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    compare();

    // Single word, LSB and MSB order.
    step(1, 32'h44332211, 0, 0, acc);
    chk("push1_rd_valid", 32'(rd_valid), 32'd1);
    chk("push1_rd_data",  32'(rd_data),  32'h11);
    chk("push1_level",    32'(level),    32'd1);
    chk("push1_rd_last",  32'(rd_last),  32'd0);
    chk("push1_m_data",   32'(m_rd_data), 32'h44);
    step(0, 0, 1, 0, acc);
    chk("lsb_u1", 32'(rd_data), 32'h22);
    chk("msb_u1", 32'(m_rd_data), 32'h33);
    step(0, 0, 1, 0, acc);
    chk("lsb_u2", 32'(rd_data), 32'h33);
    chk("msb_u2", 32'(m_rd_data), 32'h22);
    chk("u2_last", 32'(rd_last), 32'd0);
    step(0, 0, 1, 0, acc);
    chk("lsb_u3", 32'(rd_data), 32'h44);
    chk("msb_u3", 32'(m_rd_data), 32'h11);
    chk("u3_last", 32'(rd_last), 32'd1);
    step(0, 0, 1, 0, acc);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_data",  32'(rd_data), 32'd0);

    // Fill past full; fifth word must be refused.
    for (int i = 0; i < 5; i++) begin
      step(1, {4{8'hA0 + 8'(i)}}, 0, 0, acc);
      if (i == 3) chk("full_after4", 32'(full), 32'd1);
    end
    chk("full_level",    32'(level),    32'd4);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_byte", 32'(rd_data), 32'(8'hA0 + 8'(i / 4)));
      step(0, 0, 1, 0, acc);
    end
    chk("drain16_empty", 32'(empty), 32'd1);

    // Push and word-pop in the same cycle.
    step(1, 32'h0D0C0B0A, 0, 0, acc);
    step(1, 32'h1D1C1B1A, 0, 0, acc);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, acc);
    chk("lane3_data", 32'(rd_data), 32'h0D);
    chk("lane3_last", 32'(rd_last), 32'd1);
    step(1, 32'h2D2C2B2A, 1, 0, acc);
    chk("pushpop_level", 32'(level),   32'd2);
    chk("pushpop_data",  32'(rd_data), 32'h1A);
    chk("pushpop_last",  32'(rd_last), 32'd0);

    // Ten words streamed with the consumer always ready, forcing pointer wrap.
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      w = {8'(cnt) + 8'h33, 8'(cnt) + 8'h22, 8'(cnt) + 8'h11, 8'(cnt)};
      step(cnt < 10, w, 1, 0, acc);
      if (acc) cnt++;
    end
    chk("stream_cnt",   32'(cnt),   32'd10);
    chk("stream_empty", 32'(empty), 32'd1);

    // Flush at level 3, lane 2 with a concurrent push and consume.
    for (int i = 0; i < 3; i++) step(1, 32'hC0C1C2C3 + 32'(i), 0, 0, acc);
    step(0, 0, 1, 0, acc);
    step(0, 0, 1, 0, acc);
    chk("preflush_level", 32'(level), 32'd3);
    step(1, 32'hDEADBEEF, 1, 1, acc);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    step(1, 32'h78563412, 0, 0, acc);
    chk("postflush_data",  32'(rd_data), 32'h12);
    chk("postflush_level", 32'(level),   32'd1);
    step(0, 0, 1, 0, acc);
    chk("postflush_lane1", 32'(rd_data), 32'h34);

    // Mid-word async reset at level 2, lane 1.
    step(1, 32'h99887766, 0, 0, acc);
    chk("prerst_level", 32'(level), 32'd2);
    wr_valid = 1'b0; rd_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_literals("async");
    #1 rst_n = 1'b1;
    q.delete();
    lane = 0;
    step(1, 32'h04030201, 0, 0, acc);
    chk("postrst_data", 32'(rd_data), 32'h01);

    // Random traffic with occasional flush.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0, acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
